// File: rtl/dac_stream_sequencer.sv
// Rate-timed sample FIFO sitting between the dj8 CPU bus and the 8-bit DAC register.
// The CPU queues samples at FF00; a programmable divider pops one per period onto dac_out.
module dac_stream_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [7:0]  RESET_LEVEL = 8'h80,
  parameter logic [7:0]  DIV_RESET   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we_n,
  output logic [7:0]  bus_rdata,
  output logic        rd_sel,
  output logic [7:0]  dac_out,
  output logic [3:0]  fifo_level
);

  localparam int unsigned PW         = $clog2(DEPTH);
  localparam logic [3:0]  LEVEL_FULL = 4'(DEPTH);
  localparam logic [15:0] ADDR_DATA  = 16'hFF00;
  localparam logic [15:0] ADDR_CTRL  = 16'hFF01;
  localparam logic [15:0] ADDR_DIV   = 16'hFF02;

  logic [7:0]    div_q, div_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    dac_q, dac_d;
  logic [7:0]    mem_q [DEPTH];

  logic wrEn;
  logic pushReq;
  logic ctrlWr;
  logic divWr;
  logic clearFifo;
  logic clearFlags;
  logic tick;
  logic fifoFull;
  logic fifoEmpty;
  logic doPop;
  logic doPush;
  logic setOvf;
  logic setUnf;

  assign wrEn       = ena & ~bus_we_n;
  assign pushReq    = wrEn & (bus_addr == ADDR_DATA);
  assign ctrlWr     = wrEn & (bus_addr == ADDR_CTRL);
  assign divWr      = wrEn & (bus_addr == ADDR_DIV);
  assign clearFifo  = ctrlWr & bus_wdata[1];
  assign clearFlags = ctrlWr & bus_wdata[7];

  assign fifoFull  = (level_q == LEVEL_FULL);
  assign fifoEmpty = (level_q == 4'd0);
  assign tick      = run_q & ena & (cnt_q == 8'd0);

  // A clear in the tick cycle swallows the pop: the head is discarded, not played, and no underflow.
  assign doPop  = tick & ~fifoEmpty & ~clearFifo;
  assign setUnf = tick & fifoEmpty & ~clearFifo;
  assign doPush = pushReq & (~fifoFull | doPop);
  assign setOvf = pushReq & fifoFull & ~doPop;

  // While stopped the counter tracks div, so a run 0->1 gives a full div+1 period before the first tick.
  always_comb begin
    div_d = div_q;
    run_d = run_q;
    cnt_d = cnt_q;
    if (divWr) begin
      div_d = bus_wdata;
    end
    if (ctrlWr) begin
      run_d = bus_wdata[0];
    end
    if (divWr) begin
      cnt_d = bus_wdata;
    end else if (!run_q) begin
      cnt_d = div_q;
    end else if (ena) begin
      cnt_d = (cnt_q == 8'd0) ? div_q : cnt_q - 8'd1;
    end
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    level_d = level_q;
    dac_d   = dac_q;
    if (clearFifo) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      level_d = 4'd0;
    end else begin
      if (doPop) begin
        rdPtr_d = rdPtr_q + PW'(1);
        dac_d   = mem_q[rdPtr_q];
      end
      if (doPush) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      level_d = level_q + {3'b000, doPush} - {3'b000, doPop};
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_comb begin
    ovf_d = clearFlags ? 1'b0 : ovf_q;
    unf_d = clearFlags ? 1'b0 : unf_q;
    if (setOvf) begin
      ovf_d = 1'b1;
    end
    if (setUnf) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= DIV_RESET;
      cnt_q   <= DIV_RESET;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      level_q <= 4'd0;
      dac_q   <= RESET_LEVEL;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      level_q <= level_d;
      dac_q   <= dac_d;
    end
  end

  // Storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= bus_wdata;
    end
  end

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      ADDR_CTRL: bus_rdata = {ovf_q, unf_q, fifoFull, fifoEmpty, level_q};
      ADDR_DIV:  bus_rdata = div_q;
      default:   bus_rdata = 8'h00;
    endcase
  end

  assign rd_sel     = (bus_addr == ADDR_CTRL);
  assign dac_out    = dac_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dac_stream_sequencer.sv
// Self-checking bench for dac_stream_sequencer: directed vector table, corner sequences,
// then random bus traffic against a queue-based reference model with an absolute tick schedule.
module tb_dac_stream_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [15:0] bus_addr = 16'h0000;
  logic [7:0]  bus_wdata = 8'h00;
  logic        bus_we_n = 1'b1;
  logic [7:0]  bus_rdata;
  logic        rd_sel;
  logic [7:0]  dac_out;
  logic [3:0]  fifo_level;

  int testsRun = 0;
  int testsFailed = 0;

  dac_stream_sequencer #(
    .DEPTH(DEPTH),
    .RESET_LEVEL(8'h80),
    .DIV_RESET(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we_n(bus_we_n),
    .bus_rdata(bus_rdata),
    .rd_sel(rd_sel),
    .dac_out(dac_out),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: sample queue plus the enabled-cycle number at which the next tick is due.
  logic [7:0] mQ[$];
  logic [7:0] mDac;
  logic [7:0] mDiv;
  logic       mRun;
  logic       mOvf;
  logic       mUnf;
  int         mEc;
  int         mNext;

  task automatic modelStep(input logic rstN, input logic en, input logic weN,
                           input logic [15:0] addr, input logic [7:0] wdata);
    logic wr;
    logic tick;
    logic clr;
    if (!rstN) begin
      mQ.delete();
      mDac = 8'h80;
      mDiv = 8'hFF;
      mRun = 1'b0;
      mOvf = 1'b0;
      mUnf = 1'b0;
      return;
    end
    wr = en && !weN;
    if (en) mEc++;
    tick = en && mRun && (mEc == mNext);
    if (tick) mNext = mEc + int'(mDiv) + 1;
    clr = wr && addr == 16'hFF01 && wdata[1];
    if (wr && addr == 16'hFF01 && wdata[7]) begin
      mOvf = 1'b0;
      mUnf = 1'b0;
    end
    if (tick && !clr) begin
      if (mQ.size() > 0) mDac = mQ.pop_front();
      else mUnf = 1'b1;
    end
    if (wr && addr == 16'hFF00) begin
      if (mQ.size() < DEPTH) mQ.push_back(wdata);
      else mOvf = 1'b1;
    end
    if (clr) mQ.delete();
    if (wr && addr == 16'hFF01) begin
      if (wdata[0] && !mRun) mNext = mEc + int'(mDiv) + 1;
      mRun = wdata[0];
    end
    if (wr && addr == 16'hFF02) begin
      mDiv = wdata;
      mNext = mEc + int'(wdata) + 1;
    end
  endtask

  function automatic logic [7:0] modelRead(input logic [15:0] addr);
    int n;
    n = mQ.size();
    if (addr == 16'hFF01) return {mOvf, mUnf, n == DEPTH, n == 0, 4'(n)};
    if (addr == 16'hFF02) return mDiv;
    return 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One bus cycle: drive, clock the DUT and model together, then compare just after the edge.
  task automatic applyStimulus(input logic rstN, input logic en, input logic weN,
                               input logic [15:0] addr, input logic [7:0] wdata);
    rst_n = rstN;
    ena = en;
    bus_we_n = weN;
    bus_addr = addr;
    bus_wdata = wdata;
    @(posedge clk);
    modelStep(rstN, en, weN, addr, wdata);
    #1;
    checkOutput("model dac_out", dac_out, mDac);
    checkOutput("model fifo_level", {4'h0, fifo_level}, 8'(mQ.size()));
    checkOutput("model bus_rdata", bus_rdata, modelRead(addr));
    checkOutput("model rd_sel", {7'h0, rd_sel}, {7'h0, addr == 16'hFF01});
  endtask

  task automatic writeBus(input logic [15:0] addr, input logic [7:0] wdata);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, wdata);
  endtask

  task automatic readBus(input logic [15:0] addr);
    applyStimulus(1'b1, 1'b1, 1'b1, addr, 8'h00);
  endtask

  typedef struct {
    logic        rstN;
    logic        en;
    logic        weN;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  expDac;
    logic [3:0]  expLevel;
    logic [7:0]  expRdata;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input int n, input logic rstN, input logic en, input logic weN,
                        input logic [15:0] addr, input logic [7:0] wdata,
                        input logic [7:0] expDac, input logic [3:0] expLevel, input logic [7:0] expRdata);
    vec_t v;
    v.rstN = rstN; v.en = en; v.weN = weN; v.addr = addr; v.wdata = wdata;
    v.expDac = expDac; v.expLevel = expLevel; v.expRdata = expRdata;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] rAddr;
    logic [7:0]  rData;
    int          sel;

    // Reset, 600 quiet cycles, then div=3 with three samples: ticks land 4 cycles apart.
    addVec(2,   1'b0, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h80, 4'd0, 8'h10);
    addVec(600, 1'b1, 1'b1, 1'b1, 16'hFF02, 8'h00, 8'h80, 4'd0, 8'hFF);
    addVec(1,   1'b1, 1'b1, 1'b0, 16'hFF02, 8'h03, 8'h80, 4'd0, 8'h03);
    addVec(1,   1'b1, 1'b1, 1'b0, 16'hFF00, 8'h11, 8'h80, 4'd1, 8'h00);
    addVec(1,   1'b1, 1'b1, 1'b0, 16'hFF00, 8'h22, 8'h80, 4'd2, 8'h00);
    addVec(1,   1'b1, 1'b1, 1'b0, 16'hFF00, 8'h33, 8'h80, 4'd3, 8'h00);
    addVec(1,   1'b1, 1'b1, 1'b0, 16'hFF01, 8'h01, 8'h80, 4'd3, 8'h03);
    addVec(3,   1'b1, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h80, 4'd3, 8'h03);
    addVec(4,   1'b1, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h11, 4'd2, 8'h02);
    addVec(4,   1'b1, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h22, 4'd1, 8'h01);
    addVec(4,   1'b1, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h33, 4'd0, 8'h10);
    addVec(5,   1'b1, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h33, 4'd0, 8'h50);

    mEc = 0;
    mNext = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].weN, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d dac_out", i), dac_out, vecs[i].expDac);
      checkOutput($sformatf("vec%0d fifo_level", i), {4'h0, fifo_level}, {4'h0, vecs[i].expLevel});
      checkOutput($sformatf("vec%0d bus_rdata", i), bus_rdata, vecs[i].expRdata);
    end

    // Overflow: nine pushes while stopped, ninth dropped; then div=0 plays 01..08 only.
    writeBus(16'hFF01, 8'h80);
    for (int i = 1; i <= 9; i++) writeBus(16'hFF00, 8'(i));
    readBus(16'hFF01);
    checkOutput("overflow status", bus_rdata, 8'hA8);
    writeBus(16'hFF02, 8'h00);
    writeBus(16'hFF01, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      readBus(16'hFF01);
      checkOutput($sformatf("overflow pop %0d", i), dac_out, 8'(i));
    end
    readBus(16'hFF01);
    readBus(16'hFF01);
    checkOutput("overflow byte 09 dropped", dac_out, 8'h08);

    // Full FIFO with a push landing on a tick: both succeed, new byte emerges 8 ticks later.
    writeBus(16'hFF01, 8'h80);
    for (int i = 0; i < 8; i++) writeBus(16'hFF00, 8'hA0 + 8'(i));
    writeBus(16'hFF01, 8'h01);
    writeBus(16'hFF00, 8'hB0);
    checkOutput("full push+pop level", {4'h0, fifo_level}, 8'd8);
    checkOutput("full push+pop head", dac_out, 8'hA0);
    readBus(16'hFF01);
    checkOutput("full push+pop ovf", {7'h0, bus_rdata[7]}, 8'h00);
    for (int i = 0; i < 6; i++) readBus(16'hFF01);
    checkOutput("full push+pop last old", dac_out, 8'hA7);
    readBus(16'hFF01);
    checkOutput("full push+pop new byte", dac_out, 8'hB0);

    // Flags and FIFO clear, with the clear write landing exactly on a tick.
    writeBus(16'hFF01, 8'h00);
    for (int i = 0; i < 9; i++) writeBus(16'hFF00, 8'hC0 + 8'(i));
    readBus(16'hFF01);
    checkOutput("both flags set", bus_rdata, 8'hE8);
    writeBus(16'hFF02, 8'h02);
    writeBus(16'hFF01, 8'h01);
    readBus(16'hFF01);
    readBus(16'hFF01);
    checkOutput("before clear dac", dac_out, 8'hB0);
    writeBus(16'hFF01, 8'h83);
    checkOutput("clear on tick dac", dac_out, 8'hB0);
    checkOutput("clear on tick level", {4'h0, fifo_level}, 8'd0);
    readBus(16'hFF01);
    checkOutput("status after clear", bus_rdata, 8'h10);
    readBus(16'hFF01);
    readBus(16'hFF01);
    checkOutput("run kept after clear", bus_rdata, 8'h50);
    writeBus(16'hFF02, 8'h10);
    writeBus(16'hFF00, 8'h5A);
    writeBus(16'hFF00, 8'h5B);
    writeBus(16'hFF01, 8'h80);
    readBus(16'hFF01);
    checkOutput("flag-only clear keeps fifo", bus_rdata, 8'h02);

    // Reset with five entries queued.
    for (int i = 0; i < 3; i++) writeBus(16'hFF00, 8'hC3 + 8'(i));
    readBus(16'hFF01);
    checkOutput("five queued", bus_rdata, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFF01, 8'h00);
    checkOutput("midstream reset level", {4'h0, fifo_level}, 8'd0);
    checkOutput("midstream reset dac", dac_out, 8'h80);
    checkOutput("midstream reset status", bus_rdata, 8'h10);
    readBus(16'hFF02);
    checkOutput("midstream reset div", bus_rdata, 8'hFF);

    // ena=0: writes ignored and the running timer frozen.
    writeBus(16'hFF02, 8'h03);
    writeBus(16'hFF00, 8'hD1);
    writeBus(16'hFF00, 8'hD2);
    writeBus(16'hFF01, 8'h01);
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0:       applyStimulus(1'b1, 1'b0, 1'b0, 16'hFF00, 8'hEE);
        1:       applyStimulus(1'b1, 1'b0, 1'b0, 16'hFF02, 8'h07);
        default: applyStimulus(1'b1, 1'b0, 1'b0, 16'hFF01, 8'h82);
      endcase
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFF02, 8'h00);
    checkOutput("ena=0 div write ignored", bus_rdata, 8'h03);
    checkOutput("ena=0 push ignored", {4'h0, fifo_level}, 8'd2);
    checkOutput("ena=0 no tick", dac_out, 8'h80);
    for (int i = 0; i < 3; i++) readBus(16'hFF01);
    checkOutput("frozen count resumes", dac_out, 8'h80);
    readBus(16'hFF01);
    checkOutput("tick after resume", dac_out, 8'hD1);

    // Random bus traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      rData = 8'($urandom);
      if (sel <= 4) rAddr = 16'hFF00;
      else if (sel <= 6) begin
        rAddr = 16'hFF01;
        rData[0] = ($urandom_range(0, 3) != 0);
        rData[1] = ($urandom_range(0, 7) == 0);
        rData[7] = ($urandom_range(0, 3) == 0);
      end else if (sel == 7) begin
        rAddr = 16'hFF02;
        rData = 8'($urandom_range(0, 6));
      end else if (sel == 8) rAddr = 16'($urandom);
      else rAddr = 16'hFF03;
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) >= 4, rAddr, rData);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dac_stream_sequencer.md
Name: dac_stream_sequencer

Overview:
- Memory-mapped sample scheduler that sits between the dj8 CPU bus and the 8-bit DAC output register.
- The CPU pushes samples into a small FIFO. A programmable rate timer pops one sample per period onto dac_out, so the DAC is updated at a fixed rate independent of CPU instruction timing.
- Replaces the direct single-register DAC write at FF00 in the top level; the top muxes bus_rdata onto cpu data_in when rd_sel=1.

Parameters:
- DEPTH, 8, FIFO entries; legal values 2, 4, 8 only.
- RESET_LEVEL, 8'h80, dac_out value after reset (mid-scale).
- DIV_RESET, 8'hFF, divider value after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  design enable; when 0, bus writes are ignored and the timer is frozen
- bus_addr  input  16  CPU address_out
- bus_wdata  input  8  CPU data_out
- bus_we_n  input  1  CPU write strobe, active low, one cycle per write
- bus_rdata  output  8  read data (combinational)
- rd_sel  output  1  1 when bus_addr==16'hFF01 (status read decode)
- dac_out  output  8  DAC code
- fifo_level  output  4  current occupancy, 0..DEPTH

Behaviour:
- Clocking and reset
  - One clock domain: clk.
  - rst_n is synchronous and active-low, sampled on posedge clk.
  - Reset values: dac_out=RESET_LEVEL; fifo_level=0; div=DIV_RESET; cnt=DIV_RESET; run=0; ovf=0; unf=0.
  - Reset mid-stream discards all FIFO contents.
- Register map. A write occurs only when ena=1 and bus_we_n=0.
  - FF00 write: push bus_wdata into the FIFO.
  - FF01 write (control):
    - bit0: run.
    - bit1: clear FIFO (self-clearing action, not stored).
    - bit7: clear sticky flags ovf/unf.
    - Other bits are ignored.
  - FF02 write: div.
    - Also reloads cnt with the new value in the same cycle.
  - FF01 read: bus_rdata = {ovf, unf, full, empty, fifo_level}.
  - FF02 read: bus_rdata = div.
  - Any other address: bus_rdata=8'h00, rd_sel=0.
  - Reads have no side effects.
- Timer
  - When run=1 and ena=1, cnt decrements each cycle.
  - When cnt==0, a tick is generated and cnt reloads to div. Tick period is therefore div+1 cycles; div=0 gives a tick every cycle.
  - When run=0, cnt is held at div and no ticks occur.
  - Setting run 0->1 makes the first tick occur div+1 cycles after the control write.
- Pop, on tick:
  - FIFO not empty: dac_out <= head entry on the same clock edge, and the entry is removed.
  - FIFO empty: dac_out holds its value and unf <= 1.
- Push
  - FIFO not full: the entry is written at the tail.
  - FIFO full and no simultaneous pop: data is dropped, ovf <= 1, contents unchanged.
- Simultaneous events
  - Push and pop while full: both succeed, level unchanged, ovf not set.
  - Push and tick while empty: no bypass. unf is set, the pushed data lands in the FIFO, level becomes 1, and dac_out is unchanged.
  - Clear FIFO and pop in the same cycle: clear wins, dac_out is unchanged, unf is not set.
  - A FIFO push and a control write cannot coincide, because they are different addresses.
- Flags
  - ovf and unf are sticky; only FF01 bit7=1 or reset clears them.
  - If a clear and a set occur in the same cycle, set wins.
- FIFO implementation
  - Circular buffer with read and write pointers of width log2(DEPTH); pointers wrap from DEPTH-1 to 0.
  - fifo_level is a separate counter in the range 0..DEPTH.
  - full = (fifo_level==DEPTH); empty = (fifo_level==0).
- dac_out changes only on reset or on a tick pop.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 clocks, then read FF01 and FF02.
  - Required: dac_out=8'h80, FF01 reads 8'h10 (empty=1), FF02 reads 8'hFF, no dac_out change for 600 cycles.
- Rate:
  - Stimulus: write div=3, push 8'h11, 8'h22, 8'h33, write FF01=8'h01.
  - Required: dac_out becomes 11, 22, 33 on consecutive ticks 4 cycles apart; after that, unf=1 on the next tick and dac_out stays 33.
- Overflow:
  - Stimulus: run=0, push 9 bytes 8'h01..8'h09.
  - Required: level=8, full=1, ovf=1. After run=1 with div=0, dac_out goes 01..08; 09 never appears.
- Full plus simultaneous pop:
  - Stimulus: div=0, run=1 with FIFO full; push on a tick cycle.
  - Required: level stays 8, ovf=0, new byte is output 8 ticks later.
- Flag and FIFO clear:
  - Stimulus: with ovf=unf=1, write FF01=8'h83.
  - Required: status reads 8'h10 with run kept; a write of 8'h80 clears the flags only; a tick coinciding with the clear leaves dac_out unchanged.
- Reset mid-stream and ena:
  - Stimulus: assert rst_n=0 for 1 cycle with 5 entries queued; separately, drive ena=0 while writes are attempted.
  - Required: after reset, level=0 and dac_out=8'h80. With ena=0, writes are ignored and the timer is frozen (cnt holds).
